// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO port: direction control, input synchroniser, edge IRQs.
// Optional edge-detect interrupt logic is built when GPIO_IRQ_EN is defined.
module gpio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Address,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    input  logic             Select,
    input  logic             Write,
    input  logic [WIDTH-1:0] GPIO_In,
    output logic [WIDTH-1:0] GPIO_Out,
    output logic [WIDTH-1:0] GPIO_OE,
    output logic             IRQ
);

    localparam logic [2:0] OFF_DOUT = 3'd0;
    localparam logic [2:0] OFF_DIN  = 3'd1;
    localparam logic [2:0] OFF_DIR  = 3'd2;

    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rsel;
    logic [2:0]       w_off;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused;

    assign w_off    = Address[4:2];
    assign w_wr     = Select & Write;
    assign w_rd     = Select & ~Write;
    assign w_wdata  = DataIn[WIDTH-1:0];
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_unused = ^{Address[31:5], Address[1:0], DataIn};

    assign GPIO_Out = r_dout;
    assign GPIO_OE  = r_dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= GPIO_In;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
            r_dir  <= '0;
        end else if (w_wr) begin
            if (w_off == OFF_DOUT) r_dout <= w_wdata;
            if (w_off == OFF_DIR)  r_dir  <= w_wdata;
        end
    end

`ifdef GPIO_IRQ_EN
    localparam logic [2:0] OFF_IEN   = 3'd3;
    localparam logic [2:0] OFF_ISTAT = 3'd4;
    localparam logic [2:0] OFF_ESEL  = 3'd5;

    logic [WIDTH-1:0] r_sync_q;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_irq_st;
    logic [WIDTH-1:0] r_edge_sel;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    assign w_edge = (w_sync & ~r_sync_q & ~r_edge_sel)
                  | (~w_sync & r_sync_q & r_edge_sel);
    assign w_clr  = (w_wr && w_off == OFF_ISTAT) ? w_wdata : '0;
    assign IRQ    = |(r_irq_st & r_irq_en);

    // New edges are OR'd in after the clear so a same-cycle edge wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_q   <= '0;
            r_irq_en   <= '0;
            r_irq_st   <= '0;
            r_edge_sel <= '0;
        end else begin
            r_sync_q <= w_sync;
            r_irq_st <= (r_irq_st & ~w_clr) | w_edge;
            if (w_wr && w_off == OFF_IEN)  r_irq_en   <= w_wdata;
            if (w_wr && w_off == OFF_ESEL) r_edge_sel <= w_wdata;
        end
    end
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        w_rsel = '0;
        case (w_off)
            OFF_DOUT:  w_rsel = r_dout;
            OFF_DIN:   w_rsel = w_sync;
            OFF_DIR:   w_rsel = r_dir;
`ifdef GPIO_IRQ_EN
            OFF_IEN:   w_rsel = r_irq_en;
            OFF_ISTAT: w_rsel = r_irq_st;
            OFF_ESEL:  w_rsel = r_edge_sel;
`endif
            default:   w_rsel = '0;
        endcase
    end

    assign DataOut = w_rd ? 32'(w_rsel) : 32'h0;

endmodule

// File: doc/gpio_port_ctrl.md
# gpio_port_ctrl

Parametrised memory-mapped GPIO controller for the single-cycle RISC-V core's data bus. It provides WIDTH pins with per-pin direction control and a metastability synchroniser on inputs. It also has optional per-pin edge-detect interrupts with write-1-to-clear status. It sits beside data memory on the bus decoder and is selected by `Select`.

## Interface
- `WIDTH`, 8: number of GPIO pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, >= 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset; asserted at 0.
- `Address`  in  32  byte address; only `Address[4:2]` is decoded.
- `DataIn`  in  32  write data from CPU; bits [WIDTH-1:0] used.
- `DataOut`  out  32  read data to CPU; combinational; upper 32-WIDTH bits are 0.
- `Select`  in  1  block selected by bus decoder.
- `Write`  in  1  1 = write access, 0 = read access; qualified by `Select`.
- `GPIO_In`  in  WIDTH  asynchronous pin inputs.
- `GPIO_Out`  out  WIDTH  registered pin output values.
- `GPIO_OE`  out  WIDTH  registered output enables; 1 = pin drives.
- `IRQ`  out  1  interrupt request; level, active-high.

## Operation
- Register map, word offset `Address[4:2]`:
  - 0 DATA_OUT (RW). Drives `GPIO_Out`.
  - 1 DATA_IN (RO). Last synchroniser stage.
  - 2 DIR (RW). Drives `GPIO_OE`.
  - 3 IRQ_EN (RW).
  - 4 IRQ_STATUS (R/W1C).
  - 5 EDGE_SEL (RW). 0 = rising, 1 = falling.
  - 6, 7 reserved: read 0, writes ignored.
- Write: `Select && Write` at a rising `clk` updates the addressed register with `DataIn[WIDTH-1:0]`. Writes to DATA_IN are ignored.
- Read: `DataOut` is a combinational mux of the addressed register. It is valid in the same cycle, with no wait state.
  - `DataOut` = 0 when `Select` = 0.
  - `DataOut` = 0 when `Write` = 1.
- Synchroniser: `GPIO_In` passes through SYNC_STAGES flops into `sync`. A separate `sync_q` flop holds the previous `sync` value.
- Edge detect, per pin i:
  - Rising: `sync[i] & ~sync_q[i]` when EDGE_SEL[i] = 0.
  - Falling: `~sync[i] & sync_q[i]` when EDGE_SEL[i] = 1.
  - A detected edge sets IRQ_STATUS[i], regardless of IRQ_EN.
- W1C: writing 1 to IRQ_STATUS bit i clears it; writing 0 has no effect.
  - If an edge on pin i and a W1C of bit i occur in the same cycle, set wins and the bit stays 1.
- `IRQ` = |(IRQ_STATUS & IRQ_EN), combinational from registers.
- Edge detection also runs on pins configured as outputs, so a pin can loop back and interrupt on its own output.
- Reset (`rst` = 0), asynchronous. All registers, synchroniser flops and `sync_q` clear to 0. Resulting outputs:
  - `GPIO_Out` = 0.
  - `GPIO_OE` = 0, so all pins are inputs.
  - `IRQ` = 0.
  - `DataOut` = 0.
- Reset while a pin is high: after release, `sync_q` starts from 0, so a high input produces one rising edge SYNC_STAGES+1 cycles after the first clock.

## Timing
- Register write to `GPIO_Out`/`GPIO_OE`: 1 cycle, visible after the write edge.
- Pin change to DATA_IN readable: SYNC_STAGES rising edges.
- Pin edge to IRQ_STATUS set and `IRQ` high: SYNC_STAGES+1 rising edges.
- W1C to `IRQ` low: visible after the write edge, unless another edge arrives in the same cycle.
- Read after write of the same register, back-to-back cycles: returns the new value.

## Configuration
- `GPIO_IRQ_EN` defined: the edge-detect, IRQ_EN, IRQ_STATUS and EDGE_SEL logic is present as described above.
- `GPIO_IRQ_EN` undefined: that logic is not instantiated.
  - `IRQ` is tied to 0.
  - Offsets 3, 4 and 5 read 0 and ignore writes.
  - `sync_q` is removed.
  - DATA_OUT, DATA_IN and DIR are unaffected.

## Test plan
- Reset: hold `rst` = 0 with `GPIO_In` = 8'hFF. Then `GPIO_Out` = 0, `GPIO_OE` = 0, `IRQ` = 0, and a read of every offset returns 0.
- Output path: write 8'hA5 to offset 0 and 8'h0F to offset 2. Next cycle `GPIO_Out` = 8'hA5 and `GPIO_OE` = 8'h0F. Reading offsets 0 and 2 returns 32'h000000A5 and 32'h0000000F.
- Synchroniser latency: step `GPIO_In` from 8'h00 to 8'h3C. DATA_IN reads 8'h00 for 1 cycle and 8'h3C after 2 edges, with SYNC_STAGES = 2.
- Edge IRQ: set IRQ_EN = 8'h03 and EDGE_SEL = 8'h02.
  - Rise pin 0 and fall pin 1: IRQ_STATUS = 8'h03 and `IRQ` = 1 after 3 edges.
  - W1C 8'h01: status = 8'h02, `IRQ` stays 1.
  - W1C 8'h02: `IRQ` = 0.
- Set-wins collision: issue a W1C of bit 0 in the same cycle that a rising edge on pin 0 is detected. IRQ_STATUS[0] stays 1.
- Reset mid-operation: with status = 8'hFF and `GPIO_Out` = 8'hFF, pulse `rst` low asynchronously between clock edges. All outputs drop to 0 immediately, without waiting for a `clk` edge.
- With `GPIO_IRQ_EN` undefined: toggle pins with IRQ_EN written to 8'hFF. `IRQ` stays 0 and offset 4 reads 0.
